// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped timer peripheral: register
// indices, CTRL/STATUS bit positions and the run-state encoding.
package periph_pkg;

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_PRESCALE = 4'd1;
  localparam logic [3:0] REG_RELOAD   = 4'd2;
  localparam logic [3:0] REG_COUNT    = 4'd3;
  localparam logic [3:0] REG_STATUS   = 4'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_EXP  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/periph_prescaler.sv
// Prescale divider: counts enabled cycles and emits a one-cycle tick when the
// count matches the programmed prescale value, then restarts from zero.
module periph_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tick
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;

  // Tick only while enabled, so a stopped timer never produces one.
  assign o_tick = i_en && (r_cnt == i_prescale);

  // Prescale counter: clear has priority; wraps naturally at full width.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/periph_timer.sv
// Down-counting timer slave for the peripheral bus: prescaled count,
// one-shot or auto-reload, sticky expiry flag and a level IRQ.
module periph_timer
  import periph_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        rw,
  input  logic [3:0]  address_reg,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq
);

  state_t                    r_state;
  logic                      r_en;
  logic                      r_auto;
  logic                      r_irq_en;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [COUNT_WIDTH-1:0]    r_reload;
  logic [COUNT_WIDTH-1:0]    r_count;
  logic                      r_exp;
  logic                      r_irq;

  logic w_wr;
  logic w_rd;
  logic w_wr_ctrl;
  logic w_wr_prescale;
  logic w_wr_reload;
  logic w_wr_count;
  logic w_wr_status;
  logic w_ctrl_stop;
  logic w_pre_en;
  logic w_pre_clr;
  logic w_tick;
  logic w_tick_eff;
  logic w_expire;
  logic w_exp_nxt;
  logic w_irq_en_nxt;

  assign w_wr          = ce & rw;
  assign w_rd          = ce & ~rw;
  assign w_wr_ctrl     = w_wr && (address_reg == REG_CTRL);
  assign w_wr_prescale = w_wr && (address_reg == REG_PRESCALE);
  assign w_wr_reload   = w_wr && (address_reg == REG_RELOAD);
  assign w_wr_count    = w_wr && (address_reg == REG_COUNT);
  assign w_wr_status   = w_wr && (address_reg == REG_STATUS);

  // A stop write freezes the prescaler on that very edge, discarding any tick.
  assign w_ctrl_stop = w_wr_ctrl && !data_in[CTRL_EN];
  assign w_pre_en    = (r_state == RUN) && !w_ctrl_stop;
  // Restart the prescale phase when starting from idle or when COUNT is loaded.
  assign w_pre_clr   = (w_wr_ctrl && data_in[CTRL_EN] && (r_state == IDLE)) || w_wr_count;

  periph_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .i_en       (w_pre_en),
    .i_clr      (w_pre_clr),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );

  // A COUNT write on a tick cycle overrides the tick entirely.
  assign w_tick_eff   = w_tick && !w_wr_count;
  assign w_expire     = w_tick_eff && (r_count == '0);
  // Expiry set beats a software clear in the same cycle.
  assign w_exp_nxt    = w_expire || (r_exp && !(w_wr_status && data_in[STATUS_EXP]));
  assign w_irq_en_nxt = w_wr_ctrl ? data_in[CTRL_IRQ_EN] : r_irq_en;

  // Timer FSM and register file; bus writes are applied after tick handling so they win.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
      r_reload   <= '0;
      r_count    <= '0;
      r_exp      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_tick_eff) begin
        if (r_count != '0) begin
          r_count <= r_count - 1'b1;
        end else if (r_auto) begin
          r_count <= r_reload;
        end else begin
          r_en    <= 1'b0;
          r_state <= IDLE;
        end
      end
      r_exp    <= w_exp_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_exp_nxt && w_irq_en_nxt;
      if (w_wr_ctrl) begin
        r_en    <= data_in[CTRL_EN];
        r_auto  <= data_in[CTRL_AUTO];
        r_state <= data_in[CTRL_EN] ? RUN : IDLE;
      end
      if (w_wr_prescale) r_prescale <= data_in[PRESCALE_WIDTH-1:0];
      if (w_wr_reload)   r_reload   <= data_in[COUNT_WIDTH-1:0];
      if (w_wr_count)    r_count    <= data_in[COUNT_WIDTH-1:0];
    end
  end

  // Same-cycle read mux; drives zero when not selected so the bus OR works.
  always_comb begin
    data_out = '0;
    if (w_rd) begin
      case (address_reg)
        REG_CTRL: begin
          data_out[CTRL_EN]     = r_en;
          data_out[CTRL_AUTO]   = r_auto;
          data_out[CTRL_IRQ_EN] = r_irq_en;
        end
        REG_PRESCALE: data_out[PRESCALE_WIDTH-1:0] = r_prescale;
        REG_RELOAD:   data_out[COUNT_WIDTH-1:0]    = r_reload;
        REG_COUNT:    data_out[COUNT_WIDTH-1:0]    = r_count;
        REG_STATUS:   data_out[STATUS_EXP]         = r_exp;
        default:      data_out = '0;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: doc/periph_timer.md
Name: periph_timer

Overview:
- Memory-mapped down-counting timer/counter peripheral; one of the slaves selected by the peripheral controller on the MIPS address bus (address[31]=1 path).
- Consumes one ce_out/rw_out bit, the 4-bit register index (address[7:4]), and write data from the controller; returns read data and an interrupt request to the core.
- Provides a prescaled count, one-shot or auto-reload mode, and a sticky expiry flag with an optional IRQ.

Parameters:
COUNT_WIDTH, 32, width of COUNT and RELOAD registers (2..32)
PRESCALE_WIDTH, 16, width of PRESCALE register (1..16)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
ce  input  1  chip enable from the controller (its ce_out bit for this slot)
rw  input  1  1 = write, 0 = read; valid only when ce=1
address_reg  input  4  register index (CPU address[7:4])
data_in  input  32  write data (controller data_to_periph)
data_out  output  32  read data (controller data_from_periph)
irq  output  1  interrupt request, level, active-high

Behaviour:
- Register map (index: field):
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN; other bits read 0.
  - 1 PRESCALE: [PRESCALE_WIDTH-1:0].
  - 2 RELOAD: [COUNT_WIDTH-1:0].
  - 3 COUNT: read current value; write loads the counter.
  - 4 STATUS: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - Indices 5..15: read 0, writes ignored.
- Writes: take effect at the clock edge when ce=1 and rw=1. Narrower fields take the low bits of data_in.
- Reads: combinational, same cycle (monocycle core).
  - data_out = zero-extended selected register when ce=1 and rw=0; otherwise 32'h0.
  - The controller ORs slave outputs, so an unselected timer must drive 0.
- Reset: CTRL=0, PRESCALE=0, RELOAD=0, COUNT=0, prescale counter=0, EXP=0, state=IDLE, irq=0, data_out=0 (ce=0).
- State machine:
  - IDLE (EN=0): counter holds. A CTRL write with EN=1 clears the prescale counter and enters RUN.
  - RUN: prescale counter increments each cycle. When it equals PRESCALE, a tick occurs and the counter returns to 0. On each tick:
    - COUNT!=0: COUNT decrements.
    - COUNT==0: EXP set; if AUTO=1, COUNT<=RELOAD and stay in RUN; if AUTO=0, EN cleared and go to IDLE, with COUNT staying 0.
  - A CTRL write with EN=0 in RUN returns to IDLE immediately. COUNT and the prescale counter hold.
- Timing:
  - A tick occurs every PRESCALE+1 cycles.
  - From COUNT=N, expiry occurs on the (N+1)th tick.
  - Auto-reload period = (RELOAD+1)*(PRESCALE+1) cycles.
  - EXP becomes visible one cycle after the expiring edge.
- irq = EXP & IRQ_EN, driven from registered state with no combinational path from the bus.
- Simultaneous events:
  - COUNT write on a tick cycle: the write wins and the prescale counter clears.
  - STATUS clear on an expiry cycle: set wins, so EXP=1.
  - CTRL write to EN=0 on a tick cycle: the write wins and the tick is discarded.
  - PRESCALE write while running: takes effect from the next comparison. If the new value is below the current prescale count, that counter wraps at its full width; software must stop the timer first, and the bench must not rely on other behaviour.
- Reset asserted mid-count: all state returns to reset values at that edge. No tick or expiry is recorded in that cycle.
- ce=0: rw, address_reg and data_in are ignored.

Decomposition:
- Shared package periph_pkg holds:
  - register index constants: REG_CTRL=0, REG_PRESCALE=1, REG_RELOAD=2, REG_COUNT=3, REG_STATUS=4;
  - CTRL bit positions;
  - the state enum (IDLE, RUN).
- One sub-module is natural: periph_prescaler, a PRESCALE_WIDTH counter with a clear input that outputs a one-cycle tick pulse.

Test Plan:
- Reset, then read all indices 0..15 -> every read returns 32'h0 and irq=0.
- PRESCALE=0, COUNT=3, CTRL=EN|IRQ_EN (AUTO=0) -> COUNT reads 2,1,0 on the following cycles; EXP=1 and irq=1 on the 5th cycle after enable; CTRL.EN reads 0.
- PRESCALE=4, RELOAD=1, COUNT=1, CTRL=EN|AUTO -> EXP rises after 10 cycles. Clear via STATUS write 1, then EXP rises again 10 cycles later.
- STATUS clear issued on the same cycle as expiry -> EXP remains 1. A clear on the next cycle -> EXP=0 and irq=0.
- Running with COUNT=100: write COUNT=7 on a tick cycle -> COUNT reads 7 the next cycle and decrements only after PRESCALE+1 further cycles.
- Reset asserted while RUN with COUNT=50 -> next cycle COUNT=0, CTRL=0, irq=0; counting does not resume.
